// File: rtl/apb_regfile_slave.sv
// ==== apb_regfile_slave : APB4 completer over a flop-based word register file | rev 1.0 ====
`default_nettype none

module apb_regfile_slave #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int NB    = DATA_W / 8;
  localparam int AL    = $clog2(NB);
  localparam int IDX_W = ADDR_W - AL;
  localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0]     WS      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  state_t           phase;
  logic [3:0]       wait_cnt;
  logic             nosetup_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [MW-1:0]    widx;
  logic             misalign;
  logic             out_range;
  logic             no_setup;
  logic             err;

  // phase is the bus phase of the current cycle; state remembers the previous one
  always_comb begin
    phase = IDLE;
    case (state)
      IDLE:    if (psel) phase = penable ? ACCESS : SETUP;
      SETUP:   if (psel) phase = ACCESS;
      ACCESS:  if (psel) phase = penable ? ACCESS : SETUP;
      default: phase = IDLE;
    endcase
  end

  generate
    if (AL > 0) begin : g_align
      assign misalign = |paddr[AL-1:0];
    end else begin : g_noalign
      assign misalign = 1'b0;
    end
  endgenerate

  assign idx       = paddr[ADDR_W-1:AL];
  assign widx      = idx[MW-1:0];
  assign out_range = {1'b0, idx} >= DEPTH_V;
  // an access phase entered straight from IDLE stays flagged through its wait states
  assign no_setup  = (state == IDLE) | ((state == ACCESS) & nosetup_q);
  assign err       = out_range | misalign | no_setup;

  assign pready  = !rst & (phase == ACCESS) & psel & penable & (wait_cnt == WS);
  assign pslverr = pready & err;
  assign prdata  = (pready & !pwrite & !err) ? mem[widx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      nosetup_q <= 1'b0;
    end else begin
      nosetup_q <= (phase == ACCESS) & no_setup;
      if (pready) begin
        state    <= IDLE;
        wait_cnt <= 4'd0;
      end else begin
        state <= phase;
        if (phase != ACCESS)
          wait_cnt <= 4'd0;
        else if (wait_cnt < WS)
          wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (pready & pwrite & !err) begin
      for (int b = 0; b < NB; b++)
        if (pstrb[b])
          mem[widx][b*8 +: 8] <= pwdata[b*8 +: 8];
    end
  end

endmodule

`default_nettype wire
